hex_matrix_loader: RTL

Parses the ASCII-hex text stream arriving from the UART receiver into binary operand values and writes them in order into the matrix operand store. It is the input-side counterpart of the hex-to-ASCII result formatter: the host sends matrix A followed by matrix B as whitespace-separated hex tokens, such as "1F 03 A0 ...". The block sits between the `uart` receive outputs (`received`, `rx_byte`) and the operand register file feeding the matrix multiplier.

---
 rtl/hex_matrix_loader_if.sv | 26 ++
 rtl/hex_matrix_loader.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/hex_matrix_loader_if.sv
// Byte-in / operand-write bundle between the UART receiver, the hex loader
// and the operand store.
interface hex_matrix_loader_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic              clear;
  logic              received;
  logic [7:0]        rx_byte;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              done;
  logic              parse_error;
  logic              err_pulse;

  modport master (
    output clear, received, rx_byte,
    input  wr_en, wr_addr, wr_data, done, parse_error, err_pulse
  );

  modport slave (
    input  clear, received, rx_byte,
    output wr_en, wr_addr, wr_data, done, parse_error, err_pulse
  );
endinterface

// File: rtl/hex_matrix_loader.sv
// Parses whitespace-separated ASCII hex tokens into operand values and writes
// them in order to the matrix operand store.
module hex_matrix_loader #(
  parameter int NUM_VALUES = 32,
  parameter int MAX_DIGITS = 2,
  parameter int ADDR_W     = 6
) (
  input  logic                clk,
  input  logic                reset,
  hex_matrix_loader_if.slave  bus
);
  localparam int DATA_W = 4 * MAX_DIGITS;
  localparam int NDIG_W = $clog2(MAX_DIGITS + 1);

  typedef enum logic [1:0] {S_IDLE, S_DIGIT, S_SKIP, S_DONE} state_t;
  typedef enum logic [1:0] {C_DIGIT, C_SEP, C_OTHER} cls_t;

  function automatic cls_t classify(input logic [7:0] c);
    if ((c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) ||
        (c >= 8'h61 && c <= 8'h66))
      return C_DIGIT;
    if (c == 8'h20 || c == 8'h0D || c == 8'h0A || c == 8'h2C)
      return C_SEP;
    return C_OTHER;
  endfunction

  // Letters have bit 6 set and their low nibble is value-9 for both cases.
  function automatic logic [3:0] nibble(input logic [3:0] lo, input logic is_alpha);
    logic [3:0] adj;
    adj = is_alpha ? 4'd9 : 4'd0;
    return lo + adj;
  endfunction

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [NDIG_W-1:0]   ndig_q, ndig_d;
  logic [ADDR_W-1:0]   addr_cnt_q, addr_cnt_d;
  logic                rx_valid_q, rx_valid_d;
  logic [7:0]          rx_byte_q, rx_byte_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                done_q, done_d;
  logic                parse_error_q, parse_error_d;
  logic                err_pulse_q, err_pulse_d;

  cls_t                cls;
  logic [3:0]          nib;

  assign cls = classify(rx_byte_q);
  assign nib = nibble(rx_byte_q[3:0], rx_byte_q[6]);

  // The incoming byte is registered first, so the parser acts one edge later.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    ndig_d        = ndig_q;
    addr_cnt_d    = addr_cnt_q;
    rx_valid_d    = bus.received;
    rx_byte_d     = bus.received ? bus.rx_byte : rx_byte_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    done_d        = done_q;
    parse_error_d = parse_error_q;
    err_pulse_d   = 1'b0;

    if (bus.clear) begin
      state_d       = S_IDLE;
      acc_d         = '0;
      ndig_d        = '0;
      addr_cnt_d    = '0;
      rx_valid_d    = 1'b0;
      done_d        = 1'b0;
      parse_error_d = 1'b0;
    end else if (rx_valid_q) begin
      case (state_q)
        S_IDLE: begin
          if (cls == C_DIGIT) begin
            acc_d   = DATA_W'(nib);
            ndig_d  = NDIG_W'(1);
            state_d = S_DIGIT;
          end else if (cls == C_OTHER) begin
            err_pulse_d   = 1'b1;
            parse_error_d = 1'b1;
            state_d       = S_SKIP;
          end
        end
        S_DIGIT: begin
          if (cls == C_DIGIT && ndig_q < NDIG_W'(MAX_DIGITS)) begin
            acc_d  = (acc_q << 4) | DATA_W'(nib);
            ndig_d = ndig_q + NDIG_W'(1);
          end else if (cls == C_SEP) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = addr_cnt_q;
            wr_data_d  = acc_q;
            addr_cnt_d = addr_cnt_q + ADDR_W'(1);
            if (addr_cnt_q == ADDR_W'(NUM_VALUES - 1)) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            err_pulse_d   = 1'b1;
            parse_error_d = 1'b1;
            state_d       = S_SKIP;
          end
        end
        S_SKIP: begin
          if (cls == C_SEP)
            state_d = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      acc_q         <= '0;
      ndig_q        <= '0;
      addr_cnt_q    <= '0;
      rx_valid_q    <= 1'b0;
      rx_byte_q     <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      done_q        <= 1'b0;
      parse_error_q <= 1'b0;
      err_pulse_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      ndig_q        <= ndig_d;
      addr_cnt_q    <= addr_cnt_d;
      rx_valid_q    <= rx_valid_d;
      rx_byte_q     <= rx_byte_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      done_q        <= done_d;
      parse_error_q <= parse_error_d;
      err_pulse_q   <= err_pulse_d;
    end
  end

  assign bus.wr_en       = wr_en_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.done        = done_q;
  assign bus.parse_error = parse_error_q;
  assign bus.err_pulse   = err_pulse_q;
endmodule
